// File: rtl/booth_divider.sv
// Sequential signed divider: radix-2 restoring iteration on operand magnitudes,
// one quotient bit per clock, then a single sign-fixup cycle before done.
module booth_divider #(
   parameter int N_W = 16,
   parameter int D_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic           busy,
   output logic           done,
   output logic [N_W-1:0] quotient,
   output logic [D_W-1:0] remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int C_W = $clog2(N_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic [N_W-1:0] r_work;
   logic [D_W:0]   r_dmag;
   logic [D_W-1:0] r_rem;
   logic [C_W-1:0] r_cnt;
   logic           r_sign_q;
   logic           r_sign_r;
   logic           r_dz;
   logic           r_ovf;

   logic           r_busy;
   logic           r_done;
   logic [N_W-1:0] r_quot;
   logic [D_W-1:0] r_remd;
   logic           r_dz_flag;
   logic           r_ovf_flag;

   logic           w_accept;
   logic [N_W-1:0] w_dvd_mag;
   logic [D_W:0]   w_dvs_ext;
   logic [D_W:0]   w_dvs_mag;
   logic [D_W:0]   w_shift;
   logic [D_W-1:0] w_diff;
   logic           w_ge;
   logic [N_W-1:0] w_q_fix;
   logic [D_W-1:0] w_r_fix;

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_dvd_mag = dividend[N_W-1] ? -dividend : dividend;
   // One extra bit so that |-2^(D_W-1)| is representable.
   assign w_dvs_ext = {divisor[D_W-1], divisor};
   assign w_dvs_mag = divisor[D_W-1] ? -w_dvs_ext : w_dvs_ext;

   // The partial remainder stays below |divisor| <= 2^(D_W-1), so the low
   // D_W bits of the difference are exact whenever the trial succeeds.
   assign w_shift = {r_rem, r_work[N_W-1]};
   assign w_ge    = (w_shift >= r_dmag);
   assign w_diff  = w_shift[D_W-1:0] - r_dmag[D_W-1:0];

   assign w_q_fix = r_sign_q ? -r_work : r_work;
   assign w_r_fix = r_sign_r ? -r_rem : r_rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = (divisor == '0) ? S_FIX : S_CALC;
         S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
         S_FIX:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_work     <= '0;
         r_dmag     <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_dz       <= 1'b0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_quot     <= '0;
         r_remd     <= '0;
         r_dz_flag  <= 1'b0;
         r_ovf_flag <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (r_state == S_FIX);

         if (w_accept) begin
            r_sign_q <= dividend[N_W-1] ^ divisor[D_W-1];
            r_sign_r <= dividend[N_W-1];
            r_work   <= w_dvd_mag;
            r_dmag   <= w_dvs_mag;
            r_rem    <= '0;
            r_cnt    <= C_W'(N_W-1);
            r_dz     <= (divisor == '0);
            r_ovf    <= (dividend == {1'b1, {(N_W-1){1'b0}}}) && (divisor == '1);
         end

         if (r_state == S_CALC) begin
            r_rem  <= w_ge ? w_diff : w_shift[D_W-1:0];
            r_work <= {r_work[N_W-2:0], w_ge};
            r_cnt  <= r_cnt - 1'b1;
         end

         if (r_state == S_FIX) begin
            if (r_dz) begin
               r_quot     <= '0;
               r_remd     <= '0;
               r_dz_flag  <= 1'b1;
               r_ovf_flag <= 1'b0;
            end else begin
               r_quot     <= w_q_fix;
               r_remd     <= w_r_fix;
               r_dz_flag  <= 1'b0;
               r_ovf_flag <= r_ovf;
            end
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quot;
   assign remainder   = r_remd;
   assign div_by_zero = r_dz_flag;
   assign overflow    = r_ovf_flag;

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: the driver pushes reference results at
// each accept edge and a done-triggered monitor pops and compares them.
`timescale 1ns/1ps
module tb_booth_divider;

   localparam int N_W = 16;
   localparam int D_W = 8;
   localparam int N_RANDOM = 2000;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [N_W-1:0] dividend = '0;
   logic [D_W-1:0] divisor = '0;
   logic           busy;
   logic           done;
   logic [N_W-1:0] quotient;
   logic [D_W-1:0] remainder;
   logic           div_by_zero;
   logic           overflow;

   booth_divider #(.N_W(N_W), .D_W(D_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N_W-1:0] q;
      logic [D_W-1:0] r;
      logic           dz;
      logic           ov;
      int             lat;
      int             acc;
      string          tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division with the exceptional cases spelled out.
   function automatic exp_t model(input logic signed [N_W-1:0] a,
                                  input logic signed [D_W-1:0] b,
                                  input int acc, input string tag);
      exp_t e;
      int   ai, bi, qi, ri;
      ai    = int'(a);
      bi    = int'(b);
      e.acc = acc;
      e.tag = tag;
      if (bi == 0) begin
         e.q   = '0;
         e.r   = '0;
         e.dz  = 1'b1;
         e.ov  = 1'b0;
         e.lat = 1;
      end else begin
         qi    = ai / bi;
         ri    = ai % bi;
         e.q   = qi[N_W-1:0];
         e.r   = ri[D_W-1:0];
         e.dz  = 1'b0;
         e.ov  = (qi > (1 << (N_W-1)) - 1);
         e.lat = N_W + 1;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_quot"},    quotient,    e.q);
            check({e.tag, "_rem"},     remainder,   e.r);
            check({e.tag, "_dz"},      div_by_zero, e.dz);
            check({e.tag, "_ovf"},     overflow,    e.ov);
            check({e.tag, "_latency"}, cyc - e.acc, e.lat);
            check({e.tag, "_busy_at_done"}, busy, 0);
         end
      end
   end

   // Called #1 after a clock edge with the DUT idle; returns #1 after the
   // edge that completes the operation, so the next call is back-to-back.
   task automatic issue(input logic [N_W-1:0] a, input logic [D_W-1:0] b,
                        input logic hold, input string tag);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      e = model(a, b, cyc, tag);
      sb.push_back(e);
      check({tag, "_busy"}, busy, 1);
      if (!hold) start = 1'b0;
      dividend = N_W'($urandom);
      divisor  = D_W'($urandom);
      repeat (e.lat) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_quot"}, quotient, 0);
      check({tag, "_rem"},  remainder, 0);
      check({tag, "_dz"},   div_by_zero, 0);
      check({tag, "_ovf"},  overflow, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N_W-1:0] ra;
      logic [D_W-1:0] rb;
      exp_t           e;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      issue(N_W'(100),    D_W'(7),    1'b0, "p100_d7");
      issue(N_W'(-100),   D_W'(7),    1'b0, "m100_d7");
      issue(N_W'(100),    D_W'(-7),   1'b0, "p100_m7");
      issue(N_W'(-100),   D_W'(-7),   1'b0, "m100_m7");
      issue(N_W'(-32768), D_W'(-1),   1'b0, "ovf");
      issue(N_W'(32767),  D_W'(-128), 1'b0, "max_m128");
      issue(N_W'(-32768), D_W'(-128), 1'b0, "min_m128");
      issue(N_W'(1234),   D_W'(0),    1'b0, "div0");
      issue(N_W'(9),      D_W'(3),    1'b0, "after_div0");

      // A second start mid-operation must be ignored; results hold across accept.
      dividend = N_W'(1000);
      divisor  = D_W'(10);
      start    = 1'b1;
      @(posedge clk); #1;
      e = model(N_W'(1000), D_W'(10), cyc, "ignore_start");
      sb.push_back(e);
      start = 1'b0;
      check("hold_quot_across_accept", quotient, 3);
      repeat (4) @(posedge clk);
      #1;
      dividend = N_W'(-7);
      divisor  = D_W'(2);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (N_W + 1 - 5) @(posedge clk);
      #1;
      repeat (3) @(posedge clk);
      #1;
      check("hold_quot_idle", quotient, 100);

      // Reset in the middle of an operation aborts it without a done pulse.
      dividend = N_W'(5000);
      divisor  = D_W'(-3);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      issue(N_W'(50), D_W'(5), 1'b0, "after_rst");

      // Back-to-back random regression with start held high.
      for (int i = 0; i < N_RANDOM; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? {1'b1, {(N_W-1){1'b0}}} : N_W'($urandom);
         case ($urandom_range(0, 7))
            0: rb = {1'b1, {(D_W-1){1'b0}}};
            1: rb = '1;
            default: begin
               rb = D_W'($urandom);
               if (rb == '0) rb = D_W'(1);
            end
         endcase
         issue(ra, rb, 1'b1, "rnd");
      end
      start = 1'b0;

      for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
